// File: rtl/ddfs_phase_accumulator_if.sv
// DDFS phase-accumulator bus: control, FTW valid/ready handshake, phase offset and LUT address.
// Latency: none (wires only).
// Backpressure: ftw_ready is driven by the slave; the master holds ftw_in/ftw_valid until accepted.
interface ddfs_phase_accumulator_if #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  enable;
    logic                  sync_clear;
    logic [ACC_WIDTH-1:0]  ftw_in;
    logic                  ftw_valid;
    logic                  ftw_ready;
    logic [ADDR_WIDTH-1:0] phase_offset;
    logic [ADDR_WIDTH-1:0] address;
    logic                  address_valid;
    logic                  wrap;

    modport master (
        output enable, sync_clear, ftw_in, ftw_valid, phase_offset,
        input  ftw_ready, address, address_valid, wrap
    );

    modport slave (
        input  enable, sync_clear, ftw_in, ftw_valid, phase_offset,
        output ftw_ready, address, address_valid, wrap
    );
endinterface

// File: rtl/ddfs_phase_accumulator.sv
// DDFS phase accumulator feeding the sine LUT address; optional address dither via DDFS_DITHER_EN.
// Latency: accumulator value reaches address one enabled clock later.
// Backpressure: ftw_ready drops while a shadow FTW waits for the next wrap.
module ddfs_phase_accumulator #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    ddfs_phase_accumulator_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  ftw_active_q, ftw_active_d;
    logic [ACC_WIDTH-1:0]  ftw_shadow_q, ftw_shadow_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  address_valid_q, address_valid_d;
    logic                  wrap_q, wrap_d;

    logic [ACC_WIDTH:0]    sum;
    logic                  carry;
    logic                  ftw_ready;
    logic                  xfer;
    logic                  load_shadow;
    logic                  load_direct;
    logic                  apply_shadow;
    logic [ADDR_WIDTH-1:0] phase_trunc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.sync_clear) begin
            state_d = bus.enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = bus.enable ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (!bus.enable) begin
                        state_d = ST_IDLE;
                    end else if (xfer) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                // The shadow survives enable=0; it only leaves on a real wrap.
                ST_PEND: begin
                    if (bus.enable && carry) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        ftw_ready = (state_q != ST_PEND);
    end

    // ------------------------------------------------------------------
    // FTW handshake and tuning-word registers
    // ------------------------------------------------------------------
    always_comb begin
        xfer         = bus.ftw_valid & ftw_ready;
        load_shadow  = xfer & (state_q == ST_RUN) & bus.enable & ~bus.sync_clear;
        load_direct  = xfer & ~load_shadow;
        apply_shadow = (state_q == ST_PEND) & (bus.sync_clear | (bus.enable & carry));
    end

    always_comb begin
        ftw_active_d = ftw_active_q;
        ftw_shadow_d = ftw_shadow_q;
        if (apply_shadow) begin
            ftw_active_d = ftw_shadow_q;
        end
        if (load_direct) begin
            ftw_active_d = bus.ftw_in;
        end
        if (load_shadow) begin
            ftw_shadow_d = bus.ftw_in;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and address path
    // ------------------------------------------------------------------
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, ftw_active_q};
        carry = sum[ACC_WIDTH];
    end

`ifdef DDFS_DITHER_EN
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 lfsr_fb;
    logic [ACC_WIDTH-1:0] dither;
    logic [ACC_WIDTH-1:0] dithered;

    // Taps 16,14,13,11 in right-shift form: feedback from bits 0,2,3,5 into bit 15.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = lfsr_q;
        if (bus.sync_clear) begin
            lfsr_d = 16'hACE1;
        end else if (bus.enable) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
    end

    // Dither stays below one address LSB so it can only ever bump the code by +1.
    always_comb begin
        dither = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < ACC_WIDTH - ADDR_WIDTH) begin
                dither[i] = lfsr_q[i];
            end
        end
        dithered    = acc_q + dither;
        phase_trunc = dithered[ACC_WIDTH-1 -: ADDR_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        phase_trunc = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
    end
`endif

    always_comb begin
        acc_d           = acc_q;
        address_d       = address_q;
        address_valid_d = bus.enable;
        wrap_d          = 1'b0;
        if (bus.sync_clear) begin
            acc_d     = '0;
            address_d = bus.phase_offset;
        end else if (bus.enable) begin
            acc_d     = sum[ACC_WIDTH-1:0];
            wrap_d    = carry;
            address_d = phase_trunc + bus.phase_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q           <= '0;
            ftw_active_q    <= '0;
            ftw_shadow_q    <= '0;
            address_q       <= '0;
            address_valid_q <= 1'b0;
            wrap_q          <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            ftw_active_q    <= ftw_active_d;
            ftw_shadow_q    <= ftw_shadow_d;
            address_q       <= address_d;
            address_valid_q <= address_valid_d;
            wrap_q          <= wrap_d;
        end
    end

    assign bus.ftw_ready     = ftw_ready;
    assign bus.address       = address_q;
    assign bus.address_valid = address_valid_q;
    assign bus.wrap          = wrap_q;

endmodule
